cc_microsequencer: RTL and testbench

Registered micro-program sequencer for the microcoded datapath. It replaces the purely combinational branch-select path with an owned micro-PC register, a wider condition field with true and inverted flag tests, a parametrised micro-subroutine return stack, a wait-for-start state and a pipeline stall input. It drives the control-store address directly every cycle.

---
 rtl/cc_microsequencer.sv | 160 ++++++++++++++++
 tb/tb_cc_microsequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cc_microsequencer.sv
// cc_microsequencer: registered micro-program sequencer.
// Owns the micro-PC, drives the control-store address every cycle, and supports
// true/inverted flag branches, IR13 branch, decode dispatch, a micro-subroutine
// return stack, a RUN/WAIT park state and a pipeline stall.
//
// Ports:
//   CC_MICROSEQUENCER_CLOCK_50    system clock, rising edge
//   CC_MICROSEQUENCER_RESET_InLow asynchronous active-low reset
//   Seq_Condition   MIR condition field
//   Seq_JumpAddr    MIR jump address
//   Seq_DecodeAddr  decode address from IR opcode bits
//   Seq_Flags       %psr flags {N,Z,V,C}
//   Seq_Ir13        IR bit 13
//   Seq_Stall       hold all state this cycle
//   Seq_Start       release from WAIT
//   Seq_Addr        registered micro-PC (control-store address)
//   Seq_Waiting     parked in WAIT
//   Seq_Overflow    sticky: CALL with full stack
//   Seq_Underflow   sticky: RET with empty stack
//   Seq_Illegal     sticky: reserved condition executed
//
// state   | meaning
// ST_RUN  | executing micro-instructions, condition field is decoded
// ST_WAIT | parked; micro-PC held until Seq_Start releases to INC
module cc_microsequencer #(
    parameter int ADDR_WIDTH  = 11,
    parameter int COND_WIDTH  = 4,
    parameter int FLAGS_WIDTH = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic                   CC_MICROSEQUENCER_CLOCK_50,
    input  logic                   CC_MICROSEQUENCER_RESET_InLow,
    input  logic [COND_WIDTH-1:0]  Seq_Condition,
    input  logic [ADDR_WIDTH-1:0]  Seq_JumpAddr,
    input  logic [ADDR_WIDTH-1:0]  Seq_DecodeAddr,
    input  logic [FLAGS_WIDTH-1:0] Seq_Flags,
    input  logic                   Seq_Ir13,
    input  logic                   Seq_Stall,
    input  logic                   Seq_Start,
    output logic [ADDR_WIDTH-1:0]  Seq_Addr,
    output logic                   Seq_Waiting,
    output logic                   Seq_Overflow,
    output logic                   Seq_Underflow,
    output logic                   Seq_Illegal
);

    localparam int SP_W  = $clog2(STACK_DEPTH) + 1;
    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int F_N = 3, F_Z = 2, F_V = 1, F_C = 0;

    typedef enum logic {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_stack [STACK_DEPTH];
    logic [SP_W-1:0]       r_sp;
    logic                  r_ovf, r_udf, r_ill;

    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_nxt, w_inc;
    logic [SP_W-1:0]       w_sp_nxt;
    logic                  w_push;
    logic                  w_ovf_nxt, w_udf_nxt, w_ill_nxt;
    logic [IDX_W-1:0]      w_top_idx, w_push_idx;

    assign w_inc      = r_addr + ADDR_WIDTH'(1);
    assign w_push_idx = IDX_W'(r_sp);
    assign w_top_idx  = IDX_W'(r_sp - SP_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_sp_nxt    = r_sp;
        w_push      = 1'b0;
        w_ovf_nxt   = r_ovf;
        w_udf_nxt   = r_udf;
        w_ill_nxt   = r_ill;
        if (!Seq_Stall) begin
            case (r_state)
                ST_WAIT: begin
                    if (Seq_Start) begin
                        w_state_nxt = ST_RUN;
                        w_addr_nxt  = w_inc;
                    end
                end
                default: begin
                    case (Seq_Condition)
                        4'b0001: w_addr_nxt = Seq_Flags[F_N]  ? Seq_JumpAddr : w_inc;
                        4'b0010: w_addr_nxt = Seq_Flags[F_Z]  ? Seq_JumpAddr : w_inc;
                        4'b0011: w_addr_nxt = Seq_Flags[F_V]  ? Seq_JumpAddr : w_inc;
                        4'b0100: w_addr_nxt = Seq_Flags[F_C]  ? Seq_JumpAddr : w_inc;
                        4'b1010: w_addr_nxt = !Seq_Flags[F_N] ? Seq_JumpAddr : w_inc;
                        4'b1011: w_addr_nxt = !Seq_Flags[F_Z] ? Seq_JumpAddr : w_inc;
                        4'b1100: w_addr_nxt = !Seq_Flags[F_V] ? Seq_JumpAddr : w_inc;
                        4'b1101: w_addr_nxt = !Seq_Flags[F_C] ? Seq_JumpAddr : w_inc;
                        4'b0101: w_addr_nxt = Seq_Ir13 ? Seq_JumpAddr : w_inc;
                        4'b0110: w_addr_nxt = Seq_JumpAddr;
                        4'b0111: w_addr_nxt = Seq_DecodeAddr;
                        4'b1000: begin
                            // Jump is taken even when the push has to be dropped.
                            w_addr_nxt = Seq_JumpAddr;
                            if (r_sp != SP_W'(STACK_DEPTH)) begin
                                w_push   = 1'b1;
                                w_sp_nxt = r_sp + SP_W'(1);
                            end else begin
                                w_ovf_nxt = 1'b1;
                            end
                        end
                        4'b1001: begin
                            if (r_sp != '0) begin
                                w_addr_nxt = r_stack[w_top_idx];
                                w_sp_nxt   = r_sp - SP_W'(1);
                            end else begin
                                w_addr_nxt = w_inc;
                                w_udf_nxt  = 1'b1;
                            end
                        end
                        4'b1110: begin
                            // Start already high means no need to park at all.
                            if (Seq_Start) w_addr_nxt  = w_inc;
                            else           w_state_nxt = ST_WAIT;
                        end
                        4'b1111: begin
                            w_addr_nxt = w_inc;
                            w_ill_nxt  = 1'b1;
                        end
                        default: w_addr_nxt = w_inc;
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge CC_MICROSEQUENCER_CLOCK_50 or negedge CC_MICROSEQUENCER_RESET_InLow) begin
        if (!CC_MICROSEQUENCER_RESET_InLow) begin
            r_state <= ST_RUN;
            r_addr  <= '0;
            r_sp    <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
            r_ill   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_sp    <= w_sp_nxt;
            r_ovf   <= w_ovf_nxt;
            r_udf   <= w_udf_nxt;
            r_ill   <= w_ill_nxt;
            if (w_push) r_stack[w_push_idx] <= w_inc;
        end
    end

    assign Seq_Addr      = r_addr;
    assign Seq_Waiting   = (r_state == ST_WAIT);
    assign Seq_Overflow  = r_ovf;
    assign Seq_Underflow = r_udf;
    assign Seq_Illegal   = r_ill;

endmodule

// File: tb/tb_cc_microsequencer.sv
module tb_cc_microsequencer;

    localparam int AW    = 11;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    cond;
    logic [AW-1:0] jump, dec;
    logic [3:0]    flags;
    logic          ir13, stall, start;
    logic [AW-1:0] addr;
    logic          waiting, ovf, udf, ill;

    cc_microsequencer #(.ADDR_WIDTH(AW), .COND_WIDTH(4), .FLAGS_WIDTH(4), .STACK_DEPTH(DEPTH)) dut (
        .CC_MICROSEQUENCER_CLOCK_50   (clk),
        .CC_MICROSEQUENCER_RESET_InLow(rst_n),
        .Seq_Condition (cond),
        .Seq_JumpAddr  (jump),
        .Seq_DecodeAddr(dec),
        .Seq_Flags     (flags),
        .Seq_Ir13      (ir13),
        .Seq_Stall     (stall),
        .Seq_Start     (start),
        .Seq_Addr      (addr),
        .Seq_Waiting   (waiting),
        .Seq_Overflow  (ovf),
        .Seq_Underflow (udf),
        .Seq_Illegal   (ill)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        bit waiting, ovf, udf, ill;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: micro-PC as an integer, return stack as a queue.
    int   m_pc;
    int   m_stk[$];
    bit   m_wait, m_ovf, m_udf, m_ill;

    function automatic void check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        m_pc = 0;
        m_stk.delete();
        m_wait = 0; m_ovf = 0; m_udf = 0; m_ill = 0;
    endtask

    task automatic step(input int c, input int j, input int d, input int f,
                        input bit ir, input bit st, input bit go);
        int   inc;
        bit   t;
        exp_t e;
        @(negedge clk);
        cond = 4'(c); jump = AW'(j); dec = AW'(d); flags = 4'(f);
        ir13 = ir; stall = st; start = go;
        inc = (m_pc + 1) % (1 << AW);
        if (!st) begin
            if (m_wait) begin
                if (go) begin m_wait = 0; m_pc = inc; end
            end else begin
                case (c)
                    1, 2, 3, 4:     begin t = f[4 - c];    m_pc = t ? j : inc; end
                    10, 11, 12, 13: begin t = !f[13 - c];  m_pc = t ? j : inc; end
                    5:  m_pc = ir ? j : inc;
                    6:  m_pc = j;
                    7:  m_pc = d;
                    8:  begin
                            if (m_stk.size() < DEPTH) m_stk.push_back(inc);
                            else m_ovf = 1;
                            m_pc = j;
                        end
                    9:  begin
                            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                            else begin m_pc = inc; m_udf = 1; end
                        end
                    14: if (go) m_pc = inc; else m_wait = 1;
                    15: begin m_pc = inc; m_ill = 1; end
                    default: m_pc = inc;
                endcase
            end
        end
        e.addr = m_pc; e.waiting = m_wait; e.ovf = m_ovf; e.udf = m_udf; e.ill = m_ill;
        q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        stall = 1'b1;
        rst_n = 1'b0;
        q.delete();
        model_reset();
        #1;
        check("reset_addr", addr, 0);
        check("reset_waiting", waiting, 0);
        check("reset_ovf", ovf, 0);
        check("reset_udf", udf, 0);
        check("reset_ill", ill, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every clock edge presents a new micro-PC; compare against the queue.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && q.size() > 0) begin
            e = q.pop_front();
            check("addr", addr, e.addr);
            check("waiting", waiting, e.waiting);
            check("overflow", ovf, e.ovf);
            check("underflow", udf, e.udf);
            check("illegal", ill, e.ill);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; stall = 1'b1; start = 1'b0; cond = '0;
        jump = '0; dec = '0; flags = '0; ir13 = 1'b0;
        do_reset();

        // NEXT counting, then reset mid-count
        repeat (3) step(0, 0, 0, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0, 0, 0);
        do_reset();
        repeat (3) step(0, 0, 0, 0, 0, 0, 0);

        // Wrap at the top address
        step(6, 2047, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Flag polarity
        step(1,  'h100, 0, 'b1000, 0, 0, 0);
        step(10, 'h100, 0, 'b1000, 0, 0, 0);
        step(13, 'h100, 0, 'b0001, 0, 0, 0);
        step(4,  'h100, 0, 'b0001, 0, 0, 0);
        step(2,  'h155, 0, 'b0100, 0, 0, 0);
        step(12, 'h166, 0, 'b0000, 0, 0, 0);

        // DECODE / IR13
        step(7, 'h123, 'h4C0, 0, 0, 0, 0);
        step(5, 'h123, 0, 0, 0, 0, 0);
        step(5, 'h123, 0, 0, 1, 0, 0);

        // Nested CALL/RET
        step(6, 'h010, 0, 0, 0, 0, 0);
        step(8, 'h200, 0, 0, 0, 0, 0);
        step(8, 'h300, 0, 0, 0, 0, 0);
        step(9, 0, 0, 0, 0, 0, 0);
        step(9, 0, 0, 0, 0, 0, 0);

        // Stack limits
        for (int i = 0; i < 5; i++) step(8, 'h400 + i * 'h10, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(9, 0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0);

        // WAIT and stall
        step(14, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step($urandom_range(0, 15), 'h7FF, 'h3AA, 'hF, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(14, 0, 0, 0, 0, 0, 1);
        step(6, 'h055, 0, 0, 0, 1, 0);
        step(15, 0, 0, 0, 0, 0, 0);

        // Sticky flags clear on reset; RET on empty stack after reset
        do_reset();
        step(9, 0, 0, 0, 0, 0, 0);
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 500; i++)
            step($urandom_range(0, 15), $urandom_range(0, 2047), $urandom_range(0, 2047),
                 $urandom_range(0, 15), 1'($urandom), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 2) != 0));

        @(negedge clk);
        stall = 1'b1;
        @(posedge clk);
        #3;
        if (q.size() != 0) check("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
